// File: rtl/u_shape.sv
// u_shape: registered sprite geometry for one pixel per clock (U obstacle, player, double-sine bar field).
// Latency: one cycle from pix_x/pix_y (and geometry inputs) to the draw_* flags.
// Backpressure: none; a new pixel is accepted every clock and the flags are free-running.
//
// Ports:
//   clk, rst_n                        pixel clock, synchronous active-low reset
//   pix_x, pix_y                      current pixel coordinate
//   x_pos, y_pos, show_player         U position (y_pos also sets the player top row), player enable
//   x_offset, top_x/top_y,            bar-field scroll, left edge / top-band base row,
//   bottum_x/bottum_y                 right edge (exclusive) / bottom-band base row
//   bar_width, visible_width, height  bar period, lit pixels per period, band height
//   draw_U, draw_player,              registered per-shape draw flags
//   draw_double_sin
// Build option: define DOUBLE_SIN_BOTTOM_EN to include the bottom band of the bar field
// (the production build defines it); without it only the top band is drawn.
module u_shape #(
  parameter int U_W      = 48,
  parameter int U_H      = 48,
  parameter int U_T      = 8,
  parameter int PLAYER_X = 64,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       show_player,
  input  logic [9:0] x_offset,
  input  logic [9:0] top_x,
  input  logic [9:0] top_y,
  input  logic [9:0] bottum_x,
  input  logic [9:0] bottum_y,
  input  logic [9:0] bar_width,
  input  logic [9:0] visible_width,
  input  logic [9:0] height,
  output logic       draw_U,
  output logic       draw_player,
  output logic       draw_double_sin
);

  // 11-bit views so that an upper bound like x_pos+U_W cannot wrap.
  logic [10:0] px11, py11, xp11, yp11;
  assign px11 = {1'b0, pix_x};
  assign py11 = {1'b0, pix_y};
  assign xp11 = {1'b0, x_pos};
  assign yp11 = {1'b0, y_pos};

  // ---------------- U obstacle ----------------
  logic       u_in_box;
  logic [9:0] dx, dy;
  logic       u_d;

  assign u_in_box = (px11 >= xp11) && (px11 < xp11 + 11'(U_W)) &&
                    (py11 >= yp11) && (py11 < yp11 + 11'(U_H));
  // Offsets are only meaningful inside the box, where they cannot wrap.
  assign dx  = pix_x - x_pos;
  assign dy  = pix_y - y_pos;
  assign u_d = u_in_box && ((dx < 10'(U_T)) ||
                            (dx >= 10'(U_W - U_T)) ||
                            (dy >= 10'(U_H - U_T)));

  // ---------------- Player ----------------
  logic player_d;
  assign player_d = show_player &&
                    (px11 >= 11'(PLAYER_X)) && (px11 < 11'(PLAYER_X + PLAYER_W)) &&
                    (py11 >= yp11) && (py11 < yp11 + 11'(PLAYER_H));

  // ---------------- Double sine bar field ----------------
  logic [9:0]  rel;
  logic [10:0] rem;
  logic [3:0]  quo;
  logic [9:0]  phase;

  // Scroll position inside the field; intentionally wraps modulo 1024.
  assign rel = pix_x - top_x + x_offset;

  // Restoring divider, one step per dividend bit. Only the low four quotient
  // bits are kept because they alone index the sine table. With bar_width=0
  // the result is meaningless, but the draw flag is forced low in that case.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = 9; i >= 0; i--) begin
      rem = {rem[9:0], rel[i]};
      if (rem >= {1'b0, bar_width}) begin
        rem = rem - {1'b0, bar_width};
        if (i < 4) quo[i[1:0]] = 1'b1;
      end
    end
  end
  assign phase = rem[9:0];

  logic [7:0] lut_val;
  logic [7:0] sin_s;

  always_comb begin
    lut_val = 8'd128;
    case (quo)
      4'd0:  lut_val = 8'd128;
      4'd1:  lut_val = 8'd176;
      4'd2:  lut_val = 8'd218;
      4'd3:  lut_val = 8'd245;
      4'd4:  lut_val = 8'd255;
      4'd5:  lut_val = 8'd245;
      4'd6:  lut_val = 8'd218;
      4'd7:  lut_val = 8'd176;
      4'd8:  lut_val = 8'd128;
      4'd9:  lut_val = 8'd79;
      4'd10: lut_val = 8'd37;
      4'd11: lut_val = 8'd10;
      4'd12: lut_val = 8'd0;
      4'd13: lut_val = 8'd10;
      4'd14: lut_val = 8'd37;
      4'd15: lut_val = 8'd79;
      default: lut_val = 8'd128;
    endcase
  end
  // Vertical displacement 0..63.
  assign sin_s = lut_val >> 2;

  logic h_gate;
  assign h_gate = (pix_x >= top_x) && (pix_x < bottum_x) && (phase < visible_width);

  // Band sums are carried one bit wider so top_y+s+height cannot wrap either.
  logic [11:0] ty_lo, ty_hi;
  logic        top_band;
  assign ty_lo    = {2'b00, top_y} + {4'b0000, sin_s};
  assign ty_hi    = ty_lo + {2'b00, height};
  assign top_band = ({2'b00, pix_y} >= ty_lo) && ({2'b00, pix_y} < ty_hi);

  logic bar_d;

`ifdef DOUBLE_SIN_BOTTOM_EN
  // Bottom band grows upward from bottum_y, so its bounds may go negative.
  logic signed [11:0] by_hi, by_lo, by_lo_c, py_s;
  logic               bot_band;
  assign by_hi    = $signed({2'b00, bottum_y}) - $signed({4'b0000, sin_s});
  assign by_lo    = by_hi - $signed({2'b00, height});
  assign by_lo_c  = by_lo[11] ? 12'sd0 : by_lo;
  assign py_s     = $signed({2'b00, pix_y});
  assign bot_band = (py_s >= by_lo_c) && (py_s < by_hi);
  assign bar_d    = (bar_width != 10'd0) && h_gate && (top_band || bot_band);
`else
  logic unused_bottum_y;
  assign unused_bottum_y = ^bottum_y;
  assign bar_d = (bar_width != 10'd0) && h_gate && top_band;
`endif

  // ---------------- Output registers ----------------
  logic u_q, player_q, bar_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_q      <= 1'b0;
      player_q <= 1'b0;
      bar_q    <= 1'b0;
    end else begin
      u_q      <= u_d;
      player_q <= player_d;
      bar_q    <= bar_d;
    end
  end

  assign draw_U          = u_q;
  assign draw_player     = player_q;
  assign draw_double_sin = bar_q;

endmodule

// File: tb/tb_u_shape.sv
// tb_u_shape: directed vector bench for u_shape.
// Each vector drives one pixel plus geometry, waits one edge and compares {draw_U, draw_player, draw_double_sin}.
// Hand-written sequences cover reset, release, output hold between edges and mid-run reset.
module tb_u_shape;

`ifdef DOUBLE_SIN_BOTTOM_EN
  localparam bit BOT = 1'b1;
`else
  localparam bit BOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y, x_pos, y_pos, x_offset;
  logic [9:0] top_x, top_y, bottum_x, bottum_y, bar_width, visible_width, height;
  logic       show_player;
  logic       draw_U, draw_player, draw_double_sin;

  always #5 clk = ~clk;

  u_shape dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .x_pos(x_pos), .y_pos(y_pos),
    .show_player(show_player), .x_offset(x_offset),
    .top_x(top_x), .top_y(top_y), .bottum_x(bottum_x), .bottum_y(bottum_y),
    .bar_width(bar_width), .visible_width(visible_width), .height(height),
    .draw_U(draw_U), .draw_player(draw_player), .draw_double_sin(draw_double_sin)
  );

  typedef struct {
    logic [9:0] px, py, xp, yp, xo, tx, ty, bx, by, bw, vw, h;
    logic       sh;
    logic [2:0] exp; // {U, player, double_sin}
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  vec_t  base;
  int    tests = 0;
  int    fails = 0;

  task automatic add(input string n, input logic [9:0] px, input logic [9:0] py, input logic [2:0] e);
    vec_t v;
    v     = base;
    v.px  = px;
    v.py  = py;
    v.exp = e;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  task automatic drive(input vec_t v);
    pix_x = v.px; pix_y = v.py; x_pos = v.xp; y_pos = v.yp;
    show_player = v.sh; x_offset = v.xo;
    top_x = v.tx; top_y = v.ty; bottum_x = v.bx; bottum_y = v.by;
    bar_width = v.bw; visible_width = v.vw; height = v.h;
  endtask

  task automatic check(input string n, input logic [2:0] e);
    logic [2:0] got;
    got = {draw_U, draw_player, draw_double_sin};
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s: got {U,P,S}=%b expected %b", n, got, e);
    end
  endtask

  task automatic step_check(input string n, input logic [2:0] e);
    @(posedge clk);
    #1;
    check(n, e);
  endtask

  vec_t all_in;
  vec_t none_in;

  initial begin
    // Pixel (64,200) inside U (left wall), player and top band simultaneously.
    all_in = '{px:10'd64, py:10'd200, xp:10'd60, yp:10'd200, xo:10'd0,
               tx:10'd64, ty:10'd168, bx:10'd540, by:10'd400,
               bw:10'd40, vw:10'd25, h:10'd60, sh:1'b1, exp:3'b111};
    none_in     = all_in;
    none_in.px  = 10'd0;
    none_in.py  = 10'd0;
    none_in.exp = 3'b000;

    // ---- Reset / release ----
    rst_n = 1'b0;
    drive(all_in);
    @(posedge clk);
    step_check("reset_holds_zero", 3'b000);
    rst_n = 1'b1;
    step_check("release_all_in", 3'b111);

    // ---- Outputs hold between edges ----
    drive(none_in);
    #1;
    check("hold_before_edge", 3'b111);
    step_check("update_after_edge", 3'b000);

    // ---- Mid-run reset clears for one edge only ----
    drive(all_in);
    step_check("all_in_again", 3'b111);
    rst_n = 1'b0;
    step_check("midrun_reset", 3'b000);
    rst_n = 1'b1;
    step_check("midrun_release", 3'b111);

    // ---- Vector table ----
    // U at (200,100); player off; bar field disabled by bar_width=0.
    base = '{px:10'd0, py:10'd0, xp:10'd200, yp:10'd100, xo:10'd0,
             tx:10'd100, ty:10'd180, bx:10'd540, by:10'd400,
             bw:10'd0, vw:10'd25, h:10'd60, sh:1'b0, exp:3'b000};
    add("u_left_wall",   10'd203, 10'd120, 3'b100);
    add("u_interior",    10'd220, 10'd120, 3'b000);
    add("u_floor",       10'd220, 10'd145, 3'b100);
    add("u_right_out",   10'd248, 10'd120, 3'b000);
    add("u_bottom_left", 10'd200, 10'd147, 3'b100);
    add("u_right_wall",  10'd247, 10'd100, 3'b100);
    add("u_below",       10'd200, 10'd148, 3'b000);

    // Player with y_pos=200; U moved far right.
    base.xp = 10'd600; base.yp = 10'd200; base.sh = 1'b1;
    add("pl_top_left",  10'd64, 10'd200, 3'b010);
    add("pl_bot_right", 10'd79, 10'd215, 3'b010);
    add("pl_right_out", 10'd80, 10'd200, 3'b000);
    add("pl_below",     10'd64, 10'd216, 3'b000);
    add("pl_above",     10'd64, 10'd199, 3'b000);
    base.sh = 1'b0;
    add("pl_hidden",    10'd64, 10'd200, 3'b000);

    // Bar field with the reference settings.
    base.yp = 10'd0; base.bw = 10'd40;
    add("bar_top_first", 10'd100, 10'd212, 3'b001);
    add("bar_top_above", 10'd100, 10'd211, 3'b000);
    add("bar_top_below", 10'd100, 10'd272, 3'b000);
    add("bar_top_last",  10'd100, 10'd271, 3'b001);
    add("bar_unlit",     10'd125, 10'd212, 3'b000);
    add("bar_idx1_in",   10'd140, 10'd224, 3'b001);
    add("bar_idx1_out",  10'd140, 10'd223, 3'b000);
    add("bot_first",     10'd100, 10'd308, {2'b00, BOT});
    add("bot_last",      10'd100, 10'd367, {2'b00, BOT});
    add("bot_below",     10'd100, 10'd368, 3'b000);
    add("bot_above",     10'd100, 10'd307, 3'b000);
    add("bot_idx1_in",   10'd140, 10'd296, {2'b00, BOT});
    add("bot_idx1_out",  10'd140, 10'd356, 3'b000);
    add("bar_right_edge",10'd540, 10'd212, 3'b000);
    add("bar_left_out",  10'd99,  10'd212, 3'b000);

    base.bw = 10'd0;
    add("bw0_a", 10'd100, 10'd212, 3'b000);
    add("bw0_b", 10'd140, 10'd224, 3'b000);
    base.bw = 10'd40;

    base.xo = 10'd15;
    add("xoff15", 10'd100, 10'd212, 3'b001);
    base.xo = 10'd30;
    add("xoff30", 10'd100, 10'd212, 3'b000);
    base.xo = 10'd640; // quotient 16 folds back onto table entry 0
    add("xoff640_in",  10'd100, 10'd212, 3'b001);
    add("xoff640_out", 10'd100, 10'd272, 3'b000);
    base.xo = 10'd0;

    base.vw = 10'd40;
    add("vw_full", 10'd139, 10'd212, 3'b001);
    base.vw = 10'd25;
    add("vw_part", 10'd139, 10'd212, 3'b000);

    // Bottom band with a negative lower bound: rows 0..17.
    base.by = 10'd50;
    add("clamp_row0",  10'd100, 10'd0,  {2'b00, BOT});
    add("clamp_row17", 10'd100, 10'd17, {2'b00, BOT});
    add("clamp_row18", 10'd100, 10'd18, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step_check(names[i], vecs[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/u_shape.md
# u_shape

Registered sprite-geometry block for the game's video path. For each pixel coordinate it evaluates three shapes: a U-shaped obstacle at a movable position, the player sprite in a fixed column, and a double sine-modulated bar field. It produces one registered draw flag per shape, which the colour mixer downstream consumes.

## Interface
Parameters:
- U_W, 48, U outer width in pixels
- U_H, 48, U outer height in pixels
- U_T, 8, U wall and floor thickness
- PLAYER_X, 64, player left column
- PLAYER_W, 16, player width
- PLAYER_H, 16, player height

Ports:
- clk  in  1  pixel clock; one clock, all logic on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- x_pos  in  10  U left edge
- y_pos  in  10  U top edge and player top edge
- show_player  in  1  player enable
- x_offset  in  10  bar-field scroll offset
- top_x, top_y  in  10 each  bar-field left edge and top-band base row
- bottum_x, bottum_y  in  10 each  bar-field right edge (exclusive) and bottom-band base row
- bar_width  in  10  bar period in pixels
- visible_width  in  10  lit pixels per period
- height  in  10  band height in rows
- draw_U  out  1  pixel belongs to the U
- draw_player  out  1  pixel belongs to the player
- draw_double_sin  out  1  pixel belongs to the bar field

## Operation
- All box comparisons use 11-bit arithmetic, so an upper bound such as x_pos+U_W never wraps.
- U shape:
  - Let dx = pix_x − x_pos and dy = pix_y − y_pos.
  - The U is drawn when the pixel is inside the box x_pos ≤ pix_x < x_pos+U_W and y_pos ≤ pix_y < y_pos+U_H, and at least one of: dx < U_T, dx ≥ U_W−U_T, or dy ≥ U_H−U_T.
  - The interior above the floor is not drawn.
- Player: drawn when show_player=1, PLAYER_X ≤ pix_x < PLAYER_X+PLAYER_W, and y_pos ≤ pix_y < y_pos+PLAYER_H.
- Sine LUT (internal, 16 entries, 8-bit): 128,176,218,245,255,245,218,176,128,79,37,10,0,10,37,79.
- Double sine bar field:
  - rel = (pix_x − top_x + x_offset) mod 1024, as a 10-bit wrap.
  - Compute q = rel / bar_width and phase = rel mod bar_width with a combinational 10-step restoring divider.
  - idx = q[3:0]; s = LUT[idx] >> 2, giving a range of 0..63.
  - Horizontal gate: top_x ≤ pix_x < bottum_x, and phase < visible_width.
  - Top band rows: top_y+s ≤ pix_y < top_y+s+height.
  - Bottom band rows: bottum_y−s−height ≤ pix_y < bottum_y−s. Bottom-band bounds are computed signed; a negative lower bound clamps to 0.
  - draw_double_sin = horizontal gate AND (top band OR bottom band).
  - bar_width = 0 forces draw_double_sin = 0.
  - visible_width ≥ bar_width lights the whole period.

## Timing
- All three outputs are registered with 1-cycle latency. The values sampled at rising edge N appear after edge N and hold until edge N+1.
- While rst_n=0 at a rising edge, all outputs become 0 at that edge.
- The first valid output follows the first edge with rst_n=1.
- There is no handshake and no state beyond the output registers.
- A reset asserted mid-frame clears the outputs on the next edge only.

## Configuration
- DOUBLE_SIN_BOTTOM_EN defined: both bands are drawn, as described above.
- DOUBLE_SIN_BOTTOM_EN undefined: bottom-band logic is removed, and draw_double_sin = horizontal gate AND top band.
- Default build defines the macro.

## Test plan
Bar-field settings for scenarios 4–6: top_x=100, top_y=180, bottum_x=540, bottum_y=400, bar_width=40, visible_width=25, height=60.

1. Reset: rst_n=0 with pix inside all shapes → all outputs 0 one edge later. Release with the same inputs → outputs 1 one edge after release.
2. U at x_pos=200, y_pos=100 (defaults):
   - (203,120)→1
   - (220,120)→0 (interior)
   - (220,145)→1 (floor)
   - (248,120)→0 (outside)
   - (200,147)→1
3. Player at y_pos=200, show_player=1:
   - (64,200)→1
   - (79,215)→1
   - (80,200)→0
   - (64,216)→0
   - show_player=0 at (64,200)→0
4. Bar field, x_offset=0, top band:
   - pix_x=100: s=32, band 212..271. pix_y=212→1, 211→0, 272→0.
   - pix_x=125: phase 25, not lit → 0.
   - pix_x=140: idx1, s=44. pix_y=224→1, 223→0.
5. Bottom band, pix_x=100, s=32: band 308..367.
   - pix_y=308→1, 367→1, 368→0, 307→0.
   - Build without DOUBLE_SIN_BOTTOM_EN: pix_y=308→0.
6. Bar-field boundaries:
   - pix_x=540→0; pix_x=99→0.
   - bar_width=0→0 everywhere.
   - x_offset=15, pix_x=100, pix_y=212→1 (phase 15).
   - x_offset=30, pix_x=100→0 (phase 30).
